// File: rtl/conv_layer_cu.sv
// conv_layer_cu: sequences weight load, input-map streaming and
// partial-sum writeback for one convolution layer.
module conv_layer_cu #(
  parameter int IFM_SIZE = 5,
  parameter int IFM_DEPTH = 16,
  parameter int KERNAL_SIZE = 5,
  parameter int NUMBER_OF_FILTERS = 120,
  parameter int NUMBER_OF_UNITS = 3,
  parameter int STRIDE = 1,
  parameter int PIPE_LAT = 2,
  localparam int GROUPS =
    (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
  localparam int IFM_SIZE_NEXT =
    (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
  localparam int KK = KERNAL_SIZE * KERNAL_SIZE,
  localparam int ONX =
    NUMBER_OF_FILTERS * IFM_SIZE_NEXT * IFM_SIZE_NEXT,
  localparam int ISZ2 = IFM_SIZE * IFM_SIZE,
  localparam int WMN = KK * GROUPS * NUMBER_OF_FILTERS,
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int IAW = (ISZ2 > 1) ? $clog2(ISZ2) : 1,
  localparam int WAW = (WMN > 1) ? $clog2(WMN) : 1,
  localparam int BAW =
    (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1,
  localparam int OAW = (ONX > 1) ? $clog2(ONX) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_from_previous,
  input  logic           end_from_next,
  output logic           ready,
  output logic           end_to_previous,
  output logic           start_to_next,
  output logic [GW-1:0]  ifm_sel_previous,
  output logic           ifm_enable_read_current,
  output logic [IAW-1:0] ifm_address_read_current,
  output logic           wm_enable_read,
  output logic           wm_fifo_enable,
  output logic [WAW-1:0] wm_address_read_current,
  output logic           bm_enable_read,
  output logic [BAW-1:0] bm_address_read_current,
  output logic           fifo_enable,
  output logic           conv_enable,
  output logic           accu_enable,
  output logic           relu_enable,
  output logic           ifm_enable_read_next,
  output logic           ifm_enable_write_next,
  output logic [OAW-1:0] ifm_address_read_next,
  output logic [OAW-1:0] ifm_address_write_next,
  output logic           ifm_sel_next
);

  localparam int ISN2 = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int M1 = (KK > ISZ2) ? KK : ISZ2;
  localparam int MAXC = (M1 > PIPE_LAT + 1) ? M1 : PIPE_LAT + 1;
  localparam int CW = $clog2(MAXC + 1);
  localparam int RW = $clog2(IFM_SIZE + 1);

  localparam logic [CW-1:0] WL_END = CW'(KK - 1);
  localparam logic [CW-1:0] ST_END = CW'(ISZ2 - 1);
  localparam logic [CW-1:0] DR_END = CW'(PIPE_LAT);
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);
  localparam logic [BAW-1:0] F_LAST = BAW'(NUMBER_OF_FILTERS - 1);
  localparam logic [RW-1:0] C_LAST = RW'(IFM_SIZE - 1);
  localparam logic [RW-1:0] K_M1 = RW'(KERNAL_SIZE - 1);
  localparam logic [OAW-1:0] OSTEP = OAW'(ISN2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WLOAD  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]     state;
  logic [CW-1:0]  cnt;
  logic [BAW-1:0] f;
  logic [GW-1:0]  g;
  logic [RW-1:0]  r, c;
  logic [WAW-1:0] wm_addr;
  logic [OAW-1:0] obase, k;
  logic           next_free, sel_next, fifo_q;
  logic           in_stream, last_px, hit;

  logic [PIPE_LAT:0] pv, prelu, ppart;
  logic [OAW-1:0]    pa [PIPE_LAT+1];

  assign in_stream = (state == S_STREAM);
  assign last_px = (cnt == ST_END);
  // odd stride never occurs beyond 1, so parity decides the 2-stride grid
  assign hit = in_stream && (r >= K_M1) && (c >= K_M1) &&
    (STRIDE == 1 || (r[0] == K_M1[0] && c[0] == K_M1[0]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      f <= '0;
      g <= '0;
      r <= '0;
      c <= '0;
      wm_addr <= '0;
      obase <= '0;
      k <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start_from_previous) begin
          state <= S_WLOAD;
          cnt <= '0;
          f <= '0;
          g <= '0;
          wm_addr <= '0;
          obase <= '0;
          k <= '0;
        end
        S_WLOAD: begin
          wm_addr <= wm_addr + WAW'(1);
          if (cnt == WL_END) begin
            state <= S_STREAM;
            cnt <= '0;
            r <= '0;
            c <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STREAM: begin
          if (hit) k <= k + OAW'(1);
          if (c == C_LAST) begin
            c <= '0;
            r <= r + RW'(1);
          end else begin
            c <= c + RW'(1);
          end
          if (last_px) begin
            state <= S_DRAIN;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: if (cnt == DR_END) begin
          cnt <= '0;
          k <= '0;
          if (g != G_LAST) begin
            g <= g + GW'(1);
            state <= S_WLOAD;
          end else if (f != F_LAST) begin
            g <= '0;
            f <= f + BAW'(1);
            obase <= obase + OSTEP;
            state <= S_WLOAD;
          end else begin
            g <= '0;
            f <= '0;
            state <= S_WAIT;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        S_WAIT: if (start_to_next) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // pixel pipeline: stage 0 is conv, stage PIPE_LAT is writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q <= 1'b0;
      pv <= '0;
      prelu <= '0;
      ppart <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) pa[i] <= '0;
    end else begin
      fifo_q <= in_stream;
      pv <= {pv[PIPE_LAT-1:0], hit};
      prelu <= {prelu[PIPE_LAT-1:0], g == G_LAST};
      ppart <= {ppart[PIPE_LAT-1:0], g != '0};
      pa[0] <= obase + k;
      for (int i = 1; i <= PIPE_LAT; i++) pa[i] <= pa[i-1];
    end
  end

  // clear beats a simultaneous release from the next layer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_free <= 1'b1;
      sel_next <= 1'b0;
    end else if (start_to_next) begin
      next_free <= 1'b0;
      sel_next <= ~sel_next;
    end else if (end_from_next) begin
      next_free <= 1'b1;
    end
  end

  assign ready = (state == S_IDLE);
  assign start_to_next = (state == S_WAIT) &&
    (next_free || end_from_next);
  assign end_to_previous = in_stream && last_px &&
    (f == F_LAST) && (g == G_LAST);
  assign ifm_sel_previous = g;
  assign ifm_enable_read_current = in_stream;
  assign ifm_address_read_current = cnt[IAW-1:0];
  assign wm_enable_read = (state == S_WLOAD);
  assign wm_fifo_enable = (state == S_WLOAD);
  assign wm_address_read_current = wm_addr;
  assign bm_enable_read = (state == S_WLOAD) &&
    (cnt == '0) && (g == '0);
  assign bm_address_read_current = f;
  assign fifo_enable = fifo_q;
  assign conv_enable = pv[0];
  assign ifm_enable_write_next = pv[PIPE_LAT];
  assign accu_enable = pv[PIPE_LAT];
  assign relu_enable = pv[PIPE_LAT] & prelu[PIPE_LAT];
  assign ifm_address_write_next = pa[PIPE_LAT];
  assign ifm_enable_read_next = pv[PIPE_LAT-1] & ppart[PIPE_LAT-1];
  assign ifm_address_read_next = pa[PIPE_LAT-1];
  assign ifm_sel_next = sel_next;

endmodule
